hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage CPU; the counterpart of the forwarding unit. Forwarding resolves every RAW dependency it can bypass; this block handles the rest. It stalls on load-use, flushes IF/ID on taken branch or jump resolved in ID, and freezes the pipeline while data memory is not ready, with a watchdog that aborts a hung access. Outputs drive the write-enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

## Interface
- TIMEOUT, 16, number of cycles in WAIT before the access is aborted; legal range 2..255
- CNT_W, 32, width of the performance counters
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ID_rs, ID_rt  in  5  source registers of the instruction in ID
- ID_UseRs, ID_UseRt  in  1  the ID instruction actually reads rs / rt
- ID_BranchTaken  in  1  branch or jump resolved taken in ID this cycle
- EX_rd  in  5  destination register in EX
- EX_RegWrite, EX_MemRead  in  1  EX instruction writes a register / is a load
- MEM_Req  in  1  MEM stage is issuing a data-memory access
- MEM_Ready  in  1  data memory completes the access this cycle
- PC_Write, IFID_Write, IDEX_Write, EXMEM_Write  out  1  register advances when 1
- IFID_Flush, IDEX_Flush, MEMWB_Flush  out  1  register loads a bubble (NOP) when 1
- MemTimeout  out  1  one-cycle pulse: access aborted by the watchdog
- StallCnt, FlushCnt  out  CNT_W  performance counters

## Operation
- FSM states: RUN, WAIT, ABORT. The wait counter WCnt is 8 bits.
- Control outputs are combinational from the state and the inputs. State, WCnt and the counters are registered.
- Load-use hazard: LU = EX_MemRead & EX_RegWrite & (EX_rd!=0) & ((ID_UseRs & EX_rd==ID_rs) | (ID_UseRt & EX_rd==ID_rt)).
- MW (memory wait) = MEM_Req & !MEM_Ready.
- Default outputs: all *_Write=1, all *_Flush=0, MemTimeout=0.
- Output priority, highest first:
  - ABORT: IFID_Flush=IDEX_Flush=MEMWB_Flush=1, MemTimeout=1, all *_Write=1.
  - RUN with MW, or WAIT with !MEM_Ready: PC_Write, IFID_Write, IDEX_Write and EXMEM_Write all 0; MEMWB_Flush=1.
  - LU: PC_Write=IFID_Write=0, IDEX_Flush=1. IFID_Flush is suppressed, because the branch decision in ID is invalid while its operand is in flight.
  - ID_BranchTaken: IFID_Flush=1.
- WAIT with MEM_Ready behaves as RUN. LU and branch terms are evaluated normally in that cycle.
- Transitions:
  - RUN→WAIT on MW, with WCnt←1.
  - WAIT→RUN on MEM_Ready.
  - WAIT with !MEM_Ready: WCnt←WCnt+1; →ABORT when WCnt==TIMEOUT-1.
  - ABORT→RUN unconditionally.
- A MEM_Ready arriving in the same cycle that WCnt==TIMEOUT-1 wins: the FSM returns to RUN and there is no abort.
- StallCnt increments once per cycle in which PC_Write==0.
- FlushCnt increments once per cycle in which IFID_Flush==1.
- Both counters saturate at all-ones; they do not wrap.

## Timing
- Hazard controls have zero latency: they are asserted in the same cycle the condition appears.
- A load-use stall lasts exactly one cycle. On the next cycle the load is in MEM, and the forwarding unit supplies the loaded data.
- A memory freeze lasts from the first cycle of MW through the cycle in which MEM_Ready is first seen high, exclusive.
- With MEM_Ready held low: freeze for TIMEOUT cycles, then one ABORT cycle, then RUN.
- Reset: while reset=1, outputs take their defaults. At the clock edge, state←RUN, WCnt←0, StallCnt←0, FlushCnt←0.
- Reset asserted mid-WAIT or in ABORT returns the FSM to RUN on the next edge and does not pulse MemTimeout.

## Configuration
- Macro: HAZARD_PERF_CNT_EN.
- Defined: StallCnt and FlushCnt are implemented as described above.
- Undefined: the counter registers are not built, and StallCnt and FlushCnt are tied to 0. All hazard behaviour is unchanged.

## Test plan
- Load-use: EX_MemRead=1, EX_RegWrite=1, EX_rd=8; ID_rs=8, ID_UseRs=1 → one cycle with PC_Write=0, IFID_Write=0, IDEX_Flush=1, StallCnt +1. With EX_rd=0 instead → no stall.
- Load-use concurrent with branch: as above plus ID_BranchTaken=1 → IFID_Flush=0 during the stall. Next cycle, with the branch still taken → IFID_Flush=1, FlushCnt +1.
- Memory wait: MEM_Req=1 with MEM_Ready low for 3 cycles, then high → 3 cycles with all Write=0 and MEMWB_Flush=1; normal flow on the 4th cycle; StallCnt +3.
- Watchdog, TIMEOUT=4: MEM_Req=1 with MEM_Ready held low → 4 freeze cycles, then a MemTimeout pulse for 1 cycle with IFID/IDEX/MEMWB flushed, then RUN.
- Race: TIMEOUT=4, and MEM_Ready rises in the cycle where WCnt==3 → no MemTimeout; the FSM returns to RUN.
- Reset asserted in the 2nd WAIT cycle → next cycle in RUN, counters 0, MemTimeout never asserted.
- Build without HAZARD_PERF_CNT_EN → StallCnt and FlushCnt stay 0 throughout all the above scenarios.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stall, branch flush, data-memory freeze with watchdog abort.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_UseRs,
  input  logic             ID_UseRt,
  input  logic             ID_BranchTaken,
  input  logic [4:0]       EX_rd,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic             MEM_Req,
  input  logic             MEM_Ready,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IDEX_Write,
  output logic             EXMEM_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             MEMWB_Flush,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int unsigned          WCNT_W    = 8;
  localparam logic [WCNT_W-1:0]    WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              lu;
  logic              mw;
  logic              freeze;

  assign lu = EX_MemRead & EX_RegWrite & (EX_rd != 5'd0) &
              ((ID_UseRs & (EX_rd == ID_rs)) | (ID_UseRt & (EX_rd == ID_rt)));
  assign mw = MEM_Req & ~MEM_Ready;

  // A WAIT cycle that sees MEM_Ready is treated exactly like a RUN cycle.
  assign freeze = ((state_q == RUN) & mw) | ((state_q == WAIT) & ~MEM_Ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next state and hazard controls; MEM_Ready beats the watchdog on the last wait cycle.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Write  = 1'b1;
    EXMEM_Write = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    MEMWB_Flush = 1'b0;
    MemTimeout  = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mw) begin
          state_d = WAIT;
          wcnt_d  = WCNT_W'(1);
        end
      end
      WAIT: begin
        if (MEM_Ready) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
          if (wcnt_q == WCNT_LAST) begin
            state_d = ABORT;
          end
        end
      end
      ABORT: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase

    if (!reset) begin
      if (state_q == ABORT) begin
        IFID_Flush  = 1'b1;
        IDEX_Flush  = 1'b1;
        MEMWB_Flush = 1'b1;
        MemTimeout  = 1'b1;
      end else if (freeze) begin
        PC_Write    = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Write  = 1'b0;
        EXMEM_Write = 1'b0;
        MEMWB_Flush = 1'b1;
      end else if (lu) begin
        // Branch outcome in ID is stale while its operand is still loading.
        PC_Write   = 1'b0;
        IFID_Write = 1'b0;
        IDEX_Flush = 1'b1;
      end else if (ID_BranchTaken) begin
        IFID_Flush = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!PC_Write && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (IFID_Flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule
